// File: rtl/algofoogle_mult_pkg.sv
// Shared definitions for the nibble-serial multiplier: FSM state encoding and
// width helpers derived from the operand size.
package algofoogle_mult_pkg;

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_CALC,
        ST_FIX,
        ST_OUT
    } state_t;

    function automatic int op_bits(input int nibbles);
        return 4 * nibbles;
    endfunction

    function automatic int mul_bits(input int nibbles);
        return 8 * nibbles;
    endfunction

    function automatic int cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/algofoogle_shift_add_core.sv
// Radix-2 shift-add unsigned multiplier core: one multiplier bit per cycle,
// first bit retired in the start cycle, done asserted alongside the last step.
module algofoogle_shift_add_core
    import algofoogle_mult_pkg::*;
#(
    parameter int OP_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [OP_BITS-1:0]     a,
    input  logic [OP_BITS-1:0]     b,
    output logic                   done,
    output logic [2*OP_BITS-1:0]   prod
);

    localparam int CNT_W = cnt_w(OP_BITS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OP_BITS - 1);

    logic [OP_BITS-1:0] r_mcand;
    logic [OP_BITS-1:0] r_hi;
    logic [OP_BITS-1:0] r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;

    logic [OP_BITS-1:0] w_mc;
    logic [OP_BITS-1:0] w_hi;
    logic [OP_BITS-1:0] w_lo;
    logic [OP_BITS:0]   w_sum;

    // The start cycle operates on the fresh operands so no extra load cycle is spent.
    always_comb begin
        w_mc  = start ? a : r_mcand;
        w_hi  = start ? '0 : r_hi;
        w_lo  = start ? b : r_lo;
        w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_mc} : '0);
    end

    assign done = r_run && (r_cnt == LAST_STEP);
    assign prod = {r_hi, r_lo};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else if (start || r_run) begin
            r_mcand <= w_mc;
            r_hi    <= w_sum[OP_BITS:1];
            r_lo    <= {w_sum[0], w_lo[OP_BITS-1:1]};
            r_cnt   <= start ? CNT_W'(1) : r_cnt + CNT_W'(1);
            r_run   <= start ? 1'b1 : !done;
        end
    end

endmodule

// File: rtl/algofoogle_serial_mult.sv
// Nibble-serial multiplier top: nibble loader, sign handling, FSM and byte output.
// Define SERIAL_MULT_ACCUM_EN to add a wrapping product accumulator and acc_clr.
module algofoogle_serial_mult
    import algofoogle_mult_pkg::*;
#(
    parameter int OP_NIBBLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] nib_in,
    input  logic       nib_valid,
    input  logic       signed_en,
`ifdef SERIAL_MULT_ACCUM_EN
    input  logic       acc_clr,
`endif
    output logic       busy,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready
);

    localparam int OP_BITS  = op_bits(OP_NIBBLES);
    localparam int MUL_BITS = mul_bits(OP_NIBBLES);
    localparam int CNT_W    = cnt_w(OP_BITS);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(OP_NIBBLES - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_BITS-1:0]  r_a;
    logic [OP_BITS-1:0]  r_b;
    logic                r_signed;
    logic                r_neg;
    logic [MUL_BITS-1:0] r_prod;
`ifdef SERIAL_MULT_ACCUM_EN
    logic [MUL_BITS-1:0] r_acc;
`endif

    logic                w_start;
    logic                w_done;
    logic [OP_BITS-1:0]  w_a_mag;
    logic [OP_BITS-1:0]  w_b_mag;
    logic [MUL_BITS-1:0] w_core_prod;
    logic [MUL_BITS-1:0] w_result;

    assign w_start = (r_state == ST_CALC) && (r_cnt == '0);

    // -2^(OP_BITS-1) negates to itself, which reads correctly as an unsigned magnitude.
    assign w_a_mag  = (r_signed && r_a[OP_BITS-1]) ? -r_a : r_a;
    assign w_b_mag  = (r_signed && r_b[OP_BITS-1]) ? -r_b : r_b;
    assign w_result = r_neg ? -w_core_prod : w_core_prod;

    assign busy       = (r_state == ST_CALC) || (r_state == ST_FIX) || (r_state == ST_OUT);
    assign byte_valid = (r_state == ST_OUT);
    assign byte_out   = byte_valid ? r_prod[MUL_BITS-1 -: 8] : 8'h00;

    algofoogle_shift_add_core #(
        .OP_BITS (OP_BITS)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .a       (w_a_mag),
        .b       (w_b_mag),
        .done    (w_done),
        .prod    (w_core_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_LOAD_A;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_neg    <= 1'b0;
            r_prod   <= '0;
`ifdef SERIAL_MULT_ACCUM_EN
            r_acc    <= '0;
`endif
        end else begin
            case (r_state)
                ST_LOAD_A: begin
`ifdef SERIAL_MULT_ACCUM_EN
                    if (acc_clr) r_acc <= '0;
`endif
                    if (nib_valid) begin
                        r_a <= (r_a << 4) | OP_BITS'(nib_in);
                        if (r_cnt == '0) r_signed <= signed_en;
                        if (r_cnt == LAST_NIB) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOAD_B;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
`ifdef SERIAL_MULT_ACCUM_EN
                    if (acc_clr) r_acc <= '0;
`endif
                    if (nib_valid) begin
                        r_b <= (r_b << 4) | OP_BITS'(nib_in);
                        if (r_cnt == LAST_NIB) begin
                            r_cnt   <= '0;
                            r_state <= ST_CALC;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_CALC: begin
                    if (w_start) r_neg <= r_signed & (r_a[OP_BITS-1] ^ r_b[OP_BITS-1]);
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_FIX: begin
`ifdef SERIAL_MULT_ACCUM_EN
                    r_acc  <= r_acc + w_result;
                    r_prod <= r_acc + w_result;
`else
                    r_prod <= w_result;
`endif
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (byte_ready) begin
                        r_prod <= r_prod << 8;
                        if (r_cnt == LAST_NIB) begin
                            r_cnt   <= '0;
                            r_state <= ST_LOAD_A;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_algofoogle_serial_mult.sv
// Directed bench for algofoogle_serial_mult: an OP_NIBBLES=2 and an OP_NIBBLES=4
// instance share stimulus, with sel4 steering nibbles and handshake to one of them.
module tb_algofoogle_serial_mult;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] nib_in = 4'h0;
    logic       nib_valid = 1'b0;
    logic       signed_en = 1'b0;
    logic       byte_ready = 1'b0;
    logic       acc_clr = 1'b0;
    logic       sel4 = 1'b0;

    logic       busy2, busy4, bv2, bv4;
    logic [7:0] bo2, bo4;

    logic       busy, byte_valid;
    logic [7:0] byte_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign busy       = sel4 ? busy4 : busy2;
    assign byte_valid = sel4 ? bv4 : bv2;
    assign byte_out   = sel4 ? bo4 : bo2;

    algofoogle_serial_mult #(.OP_NIBBLES(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .nib_in     (nib_in),
        .nib_valid  (nib_valid & ~sel4),
        .signed_en  (signed_en),
`ifdef SERIAL_MULT_ACCUM_EN
        .acc_clr    (acc_clr),
`endif
        .busy       (busy2),
        .byte_out   (bo2),
        .byte_valid (bv2),
        .byte_ready (byte_ready & ~sel4)
    );

    algofoogle_serial_mult #(.OP_NIBBLES(4)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .nib_in     (nib_in),
        .nib_valid  (nib_valid & sel4),
        .signed_en  (signed_en),
`ifdef SERIAL_MULT_ACCUM_EN
        .acc_clr    (acc_clr),
`endif
        .busy       (busy4),
        .byte_out   (bo4),
        .byte_valid (bv4),
        .byte_ready (byte_ready & sel4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_in    = n;
        nib_valid = 1'b1;
        tick();
        nib_valid = 1'b0;
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input int nn,
                            input logic sgn);
        signed_en = sgn;
        for (int i = nn - 1; i >= 0; i--) send_nib(a[4*i +: 4]);
        signed_en = 1'b0;
        for (int i = nn - 1; i >= 0; i--) send_nib(b[4*i +: 4]);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!byte_valid && k < 200) begin
            tick();
            k++;
        end
        if (!byte_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic accept_byte(output logic [7:0] b);
        b          = byte_out;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
    endtask

    task automatic read_prod(input string tag, input int nn, output logic [63:0] p);
        logic [7:0] b;
        p = '0;
        for (int i = 0; i < nn; i++) begin
            wait_valid(tag);
            accept_byte(b);
            p = (p << 8) | 64'(b);
        end
    endtask

    // Optional accumulator clear, operand load, edge count to byte_valid, product readout.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int nn, input logic sgn, input logic clr,
                         output int lat, output logic [63:0] p);
        acc_clr = clr;
        tick();
        acc_clr = 1'b0;
        load_ops(a, b, nn, sgn);
        lat = 0;
        while (!byte_valid && lat < 200) begin
            tick();
            lat++;
        end
        read_prod(tag, nn, p);
    endtask

    initial begin
        int          lat;
        logic [63:0] p;
        logic [7:0]  b;

        repeat (3) tick();
        check("rst_busy2", 64'(busy2), 64'd0);
        check("rst_valid2", 64'(bv2), 64'd0);
        check("rst_byte2", 64'(bo2), 64'd0);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_valid4", 64'(bv4), 64'd0);
        check("rst_byte4", 64'(bo4), 64'd0);
        reset_n = 1'b1;
        tick();

        do_op("uns_ff_ff", 32'hFF, 32'hFF, 2, 1'b0, 1'b1, lat, p);
        check("uns_ff_ff", p, 64'hFE01);
        check("latency_n2", 64'(lat), 64'd9);
        check("idle_after_op", 64'(busy), 64'd0);

        do_op("sgn_ff_02", 32'hFF, 32'h02, 2, 1'b1, 1'b1, lat, p);
        check("sgn_ff_02", p, 64'hFFFE);
        do_op("sgn_80_80", 32'h80, 32'h80, 2, 1'b1, 1'b1, lat, p);
        check("sgn_80_80", p, 64'h4000);
        do_op("uns_80_80", 32'h80, 32'h80, 2, 1'b0, 1'b1, lat, p);
        check("uns_80_80", p, 64'h4000);
        do_op("sgn_fd_05", 32'hFD, 32'h05, 2, 1'b1, 1'b1, lat, p);
        check("sgn_fd_05", p, 64'hFFF1);

        // Backpressure: byte held, nibble pulses while busy are dropped.
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        load_ops(32'h12, 32'h34, 2, 1'b0);
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            nib_in    = 4'hF;
            nib_valid = 1'b1;
            tick();
            nib_valid = 1'b0;
            check($sformatf("stall_hold%0d", i), {55'd0, byte_valid, byte_out}, {55'd0, 1'b1, 8'h03});
        end
        accept_byte(b);
        check("stall_byte0", 64'(b), 64'h03);
        check("stall_byte1_live", 64'(byte_out), 64'hA8);
        nib_in     = 4'hF;
        nib_valid  = 1'b1;
        byte_ready = 1'b1;
        tick();
        nib_valid  = 1'b0;
        byte_ready = 1'b0;
        check("stall_done_idle", 64'(busy), 64'd0);
        do_op("after_stall", 32'h02, 32'h03, 2, 1'b0, 1'b1, lat, p);
        check("after_stall", p, 64'h0006);

        // Asynchronous reset in the middle of CALC.
        load_ops(32'h57, 32'h79, 2, 1'b0);
        repeat (3) tick();
        check("calc_busy", 64'(busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_out", {55'd0, busy, byte_valid, byte_out}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        do_op("post_rst", 32'h03, 32'h04, 2, 1'b0, 1'b1, lat, p);
        check("post_rst", p, 64'h000C);

        do_op("acc_first", 32'h03, 32'h04, 2, 1'b0, 1'b1, lat, p);
        check("acc_first", p, 64'h000C);
        do_op("acc_second", 32'h05, 32'h06, 2, 1'b0, 1'b0, lat, p);
`ifdef SERIAL_MULT_ACCUM_EN
        check("acc_second", p, 64'h002A);
`else
        check("acc_second", p, 64'h001E);
`endif
        do_op("acc_cleared", 32'h02, 32'h02, 2, 1'b0, 1'b1, lat, p);
        check("acc_cleared", p, 64'h0004);

        sel4 = 1'b1;
        do_op("n4_ffff", 32'hFFFF, 32'hFFFF, 4, 1'b0, 1'b1, lat, p);
        check("n4_ffff", p, 64'hFFFE0001);
        check("latency_n4", 64'(lat), 64'd17);
        do_op("n4_sgn_8000", 32'h8000, 32'h8000, 4, 1'b1, 1'b1, lat, p);
        check("n4_sgn_8000", p, 64'h40000000);
        sel4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
